// File: rtl/ps2_host_ctrl.sv
// Host-side PS/2 command transmitter: inhibits the bus, clocks out one command
// byte under device-generated clock, checks the line-ack, then resolves the
// keyboard's 0xFA/0xFE reply with bounded resends and a watchdog.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | lines released, waiting for a command
// S_INHIBIT  | holding ps2_clk low before the request-to-send
// S_REQ      | start bit driven, waiting for the device's first clock
// S_SEND     | shifting data bits and parity out on falling edges
// S_LINEACK  | stop bit released, sampling the device's line-ack
// S_WAIT_ACK | waiting for the receiver to deliver the reply byte
module ps2_host_ctrl #(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [1:0] retries
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] INH_LOAD  = IW'(INHIBIT_CYC - 1);
  localparam logic [WW-1:0] WD_LOAD   = WW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_NOACK   = 2'b10;
  localparam logic [1:0] CODE_BADRSP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_LINEACK,
    S_WAIT_ACK
  } state_t;

  state_t          state;
  logic [2:0]      clk_sync;
  logic [1:0]      data_sync;
  logic [7:0]      cmd_reg;
  logic            parity;
  logic [8:0]      shreg;
  logic [3:0]      bit_idx;
  logic [IW-1:0]   inh_cnt;
  logic [WW-1:0]   wd_cnt;
  logic            fe;
  logic            data_s;

  // Resynchronise the raw lines; idle-high reset value avoids a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  assign fe     = clk_sync[2] & ~clk_sync[1];
  assign data_s = data_sync[1];

  // Handshake flags decode straight from the registered state.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
  end

  // Command sequencer: inhibit, request, bit shifting, line-ack, reply and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      retries     <= 2'b00;
      cmd_reg     <= 8'h00;
      parity      <= 1'b0;
      shreg       <= 9'h000;
      bit_idx     <= 4'd0;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (cmd_valid) begin
            cmd_reg    <= cmd_byte;
            parity     <= ~^cmd_byte;
            retries    <= 2'b00;
            err_code   <= 2'b00;
            inh_cnt    <= INH_LOAD;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            wd_cnt      <= WD_LOAD;
            shreg       <= {parity, cmd_reg};
            bit_idx     <= 4'd0;
            state       <= S_REQ;
          end else begin
            inh_cnt <= inh_cnt - IW'(1);
          end
        end

        S_REQ, S_SEND: begin
          if (wd_cnt == '0) begin
            err         <= 1'b1;
            err_code    <= CODE_TIMEOUT;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - WW'(1);
            if (fe) begin
              if (bit_idx == 4'd9) begin
                ps2_data_oe <= 1'b0;
                state       <= S_LINEACK;
              end else begin
                ps2_data_oe <= ~shreg[0];
                shreg       <= shreg >> 1;
                bit_idx     <= bit_idx + 4'd1;
                state       <= S_SEND;
              end
            end
          end
        end

        S_LINEACK: begin
          if (fe) begin
            if (!data_s) begin
              state <= S_WAIT_ACK;
            end else begin
              err         <= 1'b1;
              err_code    <= CODE_NOACK;
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              state       <= S_IDLE;
            end
          end else if (wd_cnt == '0) begin
            err         <= 1'b1;
            err_code    <= CODE_TIMEOUT;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - WW'(1);
          end
        end

        S_WAIT_ACK: begin
          if (rx_valid) begin
            if (rx_byte == RSP_ACK) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else if (rx_byte == RSP_RESEND && retries < RETRY_MAX) begin
              retries     <= retries + 2'd1;
              inh_cnt     <= INH_LOAD;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              state       <= S_INHIBIT;
            end else begin
              err      <= 1'b1;
              err_code <= CODE_BADRSP;
              state    <= S_IDLE;
            end
          end else if (wd_cnt == '0) begin
            err         <= 1'b1;
            err_code    <= CODE_TIMEOUT;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt - WW'(1);
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: a keyboard-side bus model clocks frames out of the
// host, and a scoreboard checks every done/err pulse against outcomes
// predicted from the reply sequence.
module tb_ps2_host_ctrl;

  localparam int INH  = 20;
  localparam int TMO  = 3000;
  localparam int MAXR = 3;
  localparam int H    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_ready;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       busy, done, err;
  logic [1:0] err_code, retries;

  logic dev_clk = 1'b1;
  logic dev_data_low = 1'b0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = ~dev_data_low & ~ps2_data_oe;

  ps2_host_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .busy(busy), .done(done), .err(err),
    .err_code(err_code), .retries(retries)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [1:0] retries;
    int         frames;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event, required event", name);
  endtask

  // Monitor: inhibit length/start bit per frame, and scoreboard on done/err
  int frames_seen = 0;
  int inh_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      inh_run = 0;
      frames_seen = 0;
    end else begin
      if (ps2_clk_oe) inh_run++;
      else if (inh_run > 0) begin
        check("inhibit_len", inh_run, INH);
        check("start_bit_drive", ps2_data_oe, 1);
        frames_seen++;
        inh_run = 0;
      end
      if (done || err) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b, required none", done, err);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_err", err, mon_e.is_err);
          check("pulse_done", done, !mon_e.is_err);
          check("err_code", err_code, mon_e.code);
          check("retries", retries, mon_e.retries);
          check("frames", frames_seen, mon_e.frames);
          check("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
          check("ready_on_pulse", cmd_ready, 1);
        end
        frames_seen = 0;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] b);
    int n = 0;
    while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
    if (!cmd_ready) bound_fail("wait_ready");
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_byte  = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_request(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
    if (!ps2_clk_oe) begin bound_fail("wait_inhibit"); return; end
    n = 0;
    while (ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
    if (ps2_clk_oe) begin bound_fail("wait_release"); return; end
    ok = 1'b1;
  endtask

  // Keyboard side of one host-to-device frame: 11 clocks, bits sampled on rise
  task automatic serve_frame(input logic [7:0] b, input bit ack, input bit stray);
    bit ok;
    logic [9:0] got, req;
    wait_request(ok);
    if (!ok) return;
    repeat (3) @(negedge clk);
    got = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && ack) dev_data_low = 1'b1;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) got[i] = ps2_data_in;
      if (stray && i == 3) begin
        check("busy_in_send", busy, 1);
        check("ready_in_send", cmd_ready, 0);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_byte = 8'hFA;
        cmd_valid = 1'b1; cmd_byte = ~b;
        @(posedge clk); #1;
        rx_valid = 1'b0; cmd_valid = 1'b0;
      end
      repeat (H) @(negedge clk);
    end
    dev_data_low = 1'b0;
    for (int j = 0; j < 8; j++) req[j] = (b >> j) & 8'h01;
    req[8] = ($countones(b) % 2 == 0);
    req[9] = 1'b1;
    check("frame_bits", got, req);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 20000) begin @(negedge clk); n++; end
    if (sb.size() != 0 || busy) begin
      bound_fail("wait_idle");
      sb.delete();
    end
  endtask

  // Reference: walk the reply list by the acknowledge rules to get the outcome
  task automatic run_cmd(input logic [7:0] b, input int nfe, input logic [7:0] fin, input bit stray);
    logic [7:0] resp[$];
    exp_t e;
    int r = 0, fr = 1, used = 0;
    bit resolved = 0;
    for (int k = 0; k < nfe; k++) resp.push_back(8'hFE);
    resp.push_back(fin);
    e.is_err = 1'b0; e.code = 2'b00;
    foreach (resp[k]) begin
      if (!resolved) begin
        used++;
        if (resp[k] == 8'hFA) begin
          e.is_err = 1'b0; e.code = 2'b00; resolved = 1;
        end else if (resp[k] == 8'hFE && r < MAXR) begin
          r++; fr++;
        end else begin
          e.is_err = 1'b1; e.code = 2'b11; resolved = 1;
        end
      end
    end
    e.retries = 2'(r);
    e.frames  = fr;
    sb.push_back(e);
    send_cmd(b);
    for (int k = 0; k < used; k++) begin
      serve_frame(b, 1'b1, stray && k == 0);
      repeat (2) @(negedge clk);
      respond(resp[k]);
    end
    wait_idle();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    exp_t e;
    bit ok;
    int t0, n;
    logic [7:0] b, fin;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_retries", retries, 0);

    run_cmd(8'hED, 0, 8'hFA, 1'b0);
    run_cmd(8'hFF, 2, 8'hFA, 1'b0);
    run_cmd(8'hF3, 4, 8'hFA, 1'b0);

    // No line-ack from the device
    e.is_err = 1'b1; e.code = 2'b10; e.retries = 2'b00; e.frames = 1;
    sb.push_back(e);
    send_cmd(8'hF4);
    serve_frame(8'hF4, 1'b0, 1'b0);
    wait_idle();

    // Device never clocks: watchdog
    e.is_err = 1'b1; e.code = 2'b01; e.retries = 2'b00; e.frames = 1;
    sb.push_back(e);
    send_cmd(8'hF2);
    wait_request(ok);
    if (ok) begin
      t0 = cyc;
      n = 0;
      while (!err && n < TMO + 100) begin @(negedge clk); n++; end
      if (!err) bound_fail("wait_timeout");
      else check("timeout_cycles", cyc - t0, TMO);
    end
    wait_idle();

    // Reset in the middle of the frame after the 5th clock
    send_cmd(8'h45);
    wait_request(ok);
    if (ok) begin
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        dev_clk = 1'b0; repeat (H) @(negedge clk);
        dev_clk = 1'b1; repeat (H) @(negedge clk);
      end
      check("pre_reset_data_drive", ps2_data_oe, 1);
      #3 rst = 1'b1;
      #1;
      check("reset_release", {ps2_clk_oe, ps2_data_oe}, 0);
      check("reset_no_pulse", {done, err}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ready", cmd_ready, 1);
      check("reset_busy", busy, 0);
      repeat (50) @(negedge clk);
    end

    // Stray 0xFA and cmd_valid during SEND must be ignored
    run_cmd(8'h3C, 0, 8'hFA, 1'b1);

    for (int it = 0; it < 8; it++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        fin = 8'($urandom_range(0, 255));
        while (fin == 8'hFA || fin == 8'hFE) fin = 8'($urandom_range(0, 255));
      end else begin
        fin = 8'hFA;
      end
      run_cmd(b, int'($urandom_range(0, 4)), fin, 1'b0);
    end

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctrl.md
# ps2_host_ctrl

Host-side PS/2 command controller that sends one-byte commands to the keyboard, such as 0xFF reset, 0xED set-LEDs, or 0xF3 typematic. It sequences the bidirectional PS/2 lines and handles the keyboard's 0xFA/0xFE acknowledge protocol with bounded retries and a watchdog. It sits beside the scancode receiver: it owns the open-drain line enables, and it takes the receiver's decoded byte strobe to read the response.

## Interface
Parameters:
- INHIBIT_CYC, 10000: clk cycles ps2_clk is held low before a request (100 µs at 100 MHz).
- TIMEOUT_CYC, 2000000: watchdog from leaving INHIBIT to response (20 ms at 100 MHz).
- MAX_RETRY, 3: resends allowed after 0xFE.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2_data_in  in  1  raw PS/2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = drive ps2_clk low; 0 = release.
- ps2_data_oe  out  1  1 = drive ps2_data low; 0 = release.
- cmd_valid  in  1  command request.
- cmd_byte  in  8  command byte.
- cmd_ready  out  1  high only in IDLE; the transfer happens on cmd_valid&&cmd_ready.
- rx_valid  in  1  one-cycle strobe from the receiver, one per completed byte.
- rx_byte  in  8  byte qualified by rx_valid.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse: command acknowledged with 0xFA.
- err  out  1  one-cycle pulse: command failed.
- err_code  out  2  01 timeout, 10 no line-ack, 11 retries exhausted or unexpected response; holds until the next accept.
- retries  out  2  resend count of the last command; holds until the next accept.

## Operation
- ps2_clk_in is synchronized through 3 flops. A falling edge (fe) is sync2=1, sync1=0. ps2_data_in is synchronized through 2 flops.
- States: IDLE, INHIBIT, REQ, SEND, LINEACK, WAIT_ACK.
- IDLE: both oe=0, cmd_ready=1. On accept, latch cmd_byte, compute odd parity (ones in byte+parity is odd), clear retries and err_code, then go to INHIBIT.
- INHIBIT: clk_oe=1 for INHIBIT_CYC cycles. Then go to REQ with clk_oe=0 and data_oe=1 (start bit 0), and start the watchdog.
- REQ/SEND: a bit index counts fe events.
  - After fe k=1..8: data_oe = ~byte[k-1] (LSB first).
  - After fe 9: data_oe = ~parity.
  - After fe 10: data_oe=0 (stop bit, released). Go to LINEACK.
- LINEACK: on the next fe, sample the synchronized data. Data 0 goes to WAIT_ACK. Data 1 raises err with code 10 and returns to IDLE.
- WAIT_ACK: act on rx_valid.
  - 0xFA: done and return to IDLE.
  - 0xFE with retries<MAX_RETRY: retries++, reload the latched byte, go to INHIBIT; the watchdog restarts on leaving INHIBIT.
  - 0xFE with retries==MAX_RETRY: err with code 11.
  - Any other byte: err with code 11.
- rx_valid is ignored in every state except WAIT_ACK.
- Watchdog: runs in REQ, SEND, LINEACK and WAIT_ACK. On expiry, err with code 01, oe=0, return to IDLE. If expiry and a resolving event land on the same cycle, the resolving event wins.
- cmd_valid outside IDLE is ignored; no queueing.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, cmd_ready=1, busy=0, done=0, err=0, err_code=00, retries=00, state IDLE, all counters 0.
- Reset mid-transfer releases both lines immediately (asynchronous) and aborts with no done/err pulse.
- Accept at cycle t: clk_oe=1 from t+1 through t+INHIBIT_CYC. data_oe=1 and clk_oe=0 at t+INHIBIT_CYC+1.
- Bit drive: data_oe changes on the cycle after fe is detected. That is 4 clk after the raw edge, well within a half PS/2 period (≥30 µs).
- done/err assert the cycle after the resolving rx_valid or fe. cmd_ready returns the same cycle. A new cmd can be accepted that cycle.
- Outputs are registered; cmd_ready and busy are decoded from registered state.

## Test plan
- Send 0xED; BFM clocks 11 bits, gives line-ack, then 0xFA. Required: data bits 1,0,1,1,0,1,1,1, parity 1, stop released; done pulses once; retries=0; err_code=00.
- Send 0xFF; BFM replies 0xFE, 0xFE, 0xFA. Required: three full INHIBIT/SEND frames, each at least INHIBIT_CYC long; done; retries=2.
- Send 0xF3; BFM replies 0xFE four times. Required: four frames, then err with err_code=11 and retries=3; no done.
- BFM leaves data high at the 11th fe. Required: err, err_code=10, both oe=0 the next cycle.
- BFM never clocks after REQ. Required: err with err_code=01 exactly TIMEOUT_CYC cycles after leaving INHIBIT; lines released.
- Assert rst during SEND bit 5, and separately pulse rx_valid=0xFA while in SEND. Required: reset releases lines with no pulse and cmd_ready=1; the stray 0xFA is ignored.
